// File: rtl/spi_loader.sv
`default_nettype none
// ============================================================================
// spi_loader : deserialises 12-bit SPI frames into imem/dmem writes and
//              starts the core. Optional macro SPI_LOADER_SYNC_EN adds
//              2-flop synchronisers on sclk_in, mosi_in and mode_in.
// Revision   : 1.0
// ============================================================================
module spi_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk_in,
   input  logic              mosi_in,
   input  logic [1:0]        mode_in,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              core_start,
   input  logic              core_halt_in,
   output logic              done_out,
   output logic              frame_err
);

   localparam int FRAME_BITS = ADDR_W + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

   localparam logic [1:0] MODE_GAP  = 2'b00;
   localparam logic [1:0] MODE_IMEM = 2'b01;
   localparam logic [1:0] MODE_DMEM = 2'b10;
   localparam logic [1:0] MODE_RUN  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RX, S_WR, S_RUN} state_t;

   logic       sclk_s;
   logic       mosi_s;
   logic [1:0] mode_s;

`ifdef SPI_LOADER_SYNC_EN
   logic [1:0] sclk_sync;
   logic [1:0] mosi_sync;
   logic [1:0] mode_sync0;
   logic [1:0] mode_sync1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync  <= '0;
         mosi_sync  <= '0;
         mode_sync0 <= '0;
         mode_sync1 <= '0;
      end else begin
         sclk_sync  <= {sclk_sync[0], sclk_in};
         mosi_sync  <= {mosi_sync[0], mosi_in};
         mode_sync0 <= mode_in;
         mode_sync1 <= mode_sync0;
      end
   end

   assign sclk_s = sclk_sync[1];
   assign mosi_s = mosi_sync[1];
   assign mode_s = mode_sync1;
`else
   assign sclk_s = sclk_in;
   assign mosi_s = mosi_in;
   assign mode_s = mode_in;
`endif

   logic sclk_q;
   logic rise;
   assign rise = sclk_s & ~sclk_q;

   state_t                state, state_d;
   logic [CNT_W-1:0]      cnt, cnt_d;
   logic [FRAME_BITS-1:0] sr, sr_d;
   logic [1:0]            fmode, fmode_d;
   logic [1:0]            done_mode, done_mode_d;
   logic                  imem_we_d, dmem_we_d, core_start_d, done_d, err_d;
   logic [ADDR_W-1:0]     imem_addr_d, dmem_addr_d;
   logic [DATA_W-1:0]     imem_wdata_d, dmem_wdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q     <= 1'b0;
         state      <= S_IDLE;
         cnt        <= '0;
         sr         <= '0;
         fmode      <= MODE_GAP;
         done_mode  <= MODE_GAP;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         core_start <= 1'b0;
         done_out   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sclk_q     <= sclk_s;
         state      <= state_d;
         cnt        <= cnt_d;
         sr         <= sr_d;
         fmode      <= fmode_d;
         done_mode  <= done_mode_d;
         imem_we    <= imem_we_d;
         imem_addr  <= imem_addr_d;
         imem_wdata <= imem_wdata_d;
         dmem_we    <= dmem_we_d;
         dmem_addr  <= dmem_addr_d;
         dmem_wdata <= dmem_wdata_d;
         core_start <= core_start_d;
         done_out   <= done_d;
         frame_err  <= err_d;
      end
   end

   // Outputs are registered, so the write strobe coincides with the WR state.
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      sr_d         = sr;
      fmode_d      = fmode;
      done_mode_d  = done_mode;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr;
      dmem_wdata_d = dmem_wdata;
      core_start_d = 1'b0;
      done_d       = done_out;
      err_d        = frame_err;

      case (state)
         S_IDLE: begin
            if (mode_s == MODE_RUN) begin
               core_start_d = 1'b1;
               done_d       = 1'b0;
               state_d      = S_RUN;
            end else if ((mode_s == MODE_IMEM || mode_s == MODE_DMEM) && rise) begin
               sr_d    = {mosi_s, sr[FRAME_BITS-1:1]};
               cnt_d   = CNT_W'(1);
               fmode_d = mode_s;
               if (mode_s != done_mode) done_d = 1'b0;
               state_d = S_RX;
            end
         end
         S_RX: begin
            if (cnt == CNT_FULL) begin
               if (fmode == MODE_IMEM) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = sr[ADDR_W-1:0];
                  imem_wdata_d = sr[FRAME_BITS-1:ADDR_W];
               end else begin
                  dmem_we_d    = 1'b1;
                  dmem_addr_d  = sr[ADDR_W-1:0];
                  dmem_wdata_d = sr[FRAME_BITS-1:ADDR_W];
               end
               done_d      = &sr[ADDR_W-1:0];
               done_mode_d = fmode;
               cnt_d       = '0;
               state_d     = S_WR;
            end else if (mode_s != fmode) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (rise) begin
               sr_d  = {mosi_s, sr[FRAME_BITS-1:1]};
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_WR: state_d = S_IDLE;
         S_RUN: begin
            if (mode_s == MODE_RUN) begin
               done_d = core_halt_in;
            end else begin
               done_d  = 1'b0;
               state_d = S_IDLE;
               if (mode_s != MODE_GAP) err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_loader.sv
`default_nettype none
// tb_spi_loader : randomized directed bench for spi_loader, checked against
//                 a memory/flag reference model.
module tb_spi_loader;
`ifdef SPI_LOADER_SYNC_EN
   localparam int WR_LAT = 4;
`else
   localparam int WR_LAT = 2;
`endif
   localparam int FB = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk_in = 1'b0;
   logic       mosi_in = 1'b0;
   logic [1:0] mode_in = 2'b00;
   logic       core_halt_in = 1'b0;
   logic       imem_we, dmem_we, core_start, done_out, frame_err;
   logic [3:0] imem_addr, dmem_addr;
   logic [7:0] imem_wdata, dmem_wdata;

   spi_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .mosi_in(mosi_in), .mode_in(mode_in),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .core_start(core_start), .core_halt_in(core_halt_in),
      .done_out(done_out), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       is_dmem;
      logic [3:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   wr_t wr_q[$];
   int  cyc = 0;
   int  start_cnt = 0;
   int  tests = 0;
   int  fails = 0;
   int  rise_cyc = 0;

   logic [7:0] imem_m [16];
   logic [7:0] dmem_m [16];
   logic       done_m = 1'b0;
   logic [1:0] done_src = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) wr_q.push_back('{1'b0, imem_addr, imem_wdata, cyc});
      if (dmem_we === 1'b1) wr_q.push_back('{1'b1, dmem_addr, dmem_wdata, cyc});
      if (core_start === 1'b1) start_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      sclk_in = 1'b0;
      mosi_in = b;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      sclk_in  = 1'b1;
      rise_cyc = cyc;
      repeat ($urandom_range(1, 2)) @(negedge clk);
   endtask

   task automatic send_bits(input logic [1:0] m, input logic [3:0] a, input logic [7:0] d,
                            input int first, input int last);
      logic [11:0] f;
      f = {d, a};
      mode_in = m;
      for (int i = first; i < last; i++) send_bit(f[i]);
   endtask

   // Model: a new frame in a different mode than the one that set done clears it.
   function automatic void model_first_bit(input logic [1:0] m);
      if (m != done_src) done_m = 1'b0;
   endfunction

   task automatic do_frame(input logic [1:0] m, input logic [3:0] a, input logic [7:0] d);
      int base;
      base = wr_q.size();
      send_bits(m, a, d, 0, 1);
      model_first_bit(m);
      repeat (3) @(negedge clk);
      check("done_first_bit", done_out, done_m);
      send_bits(m, a, d, 1, FB);
      @(negedge clk);
      sclk_in = 1'b0;
      repeat (8) @(negedge clk);
      mode_in = 2'b00;
      if (m == 2'b01) imem_m[a] = d; else dmem_m[a] = d;
      done_m   = (a == 4'hF);
      done_src = m;
      check("wr_count", wr_q.size() - base, 1);
      if (wr_q.size() > base) begin
         check("wr_target", wr_q[base].is_dmem, (m == 2'b10));
         check("wr_addr", wr_q[base].addr, a);
         check("wr_data", wr_q[base].data, (m == 2'b01) ? imem_m[a] : dmem_m[a]);
         check("wr_latency", wr_q[base].cyc - rise_cyc, WR_LAT);
      end
      repeat ($urandom_range(2, 5)) @(negedge clk);
      check("done_gap", done_out, done_m);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_dmem_we"}, dmem_we, 0);
      check({tag, "_dmem_addr"}, dmem_addr, 0);
      check({tag, "_dmem_wdata"}, dmem_wdata, 0);
      check({tag, "_core_start"}, core_start, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_frame_err"}, frame_err, 0);
   endtask

   initial begin
      int         base;
      int         sbase;
      logic [1:0] m;
      logic       err_m;
      err_m = 1'b0;

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_frame(2'b01, 4'd3, 8'hA5);
      check("imem_done", done_out, 0);

      for (int a = 0; a < 16; a++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         do_frame(2'b10, 4'(a), 8'(8'h10 + a));
      end
      repeat (10) @(negedge clk);
      check("done_hold_gap", done_out, 1);

      repeat (12) begin
         m = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
         do_frame(m, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end

      // Abort: mode drops mid-frame.
      base = wr_q.size();
      send_bits(2'b01, 4'd9, 8'h55, 0, 6);
      model_first_bit(2'b01);
      @(negedge clk);
      sclk_in = 1'b0;
      mode_in = 2'b00;
      repeat (8) @(negedge clk);
      err_m = 1'b1;
      check("abort_no_write", wr_q.size() - base, 0);
      check("abort_err", frame_err, err_m);
      do_frame(2'b01, 4'd0, 8'h3C);
      check("abort_err_sticky", frame_err, err_m);

      // Run mode.
      sbase   = start_cnt;
      mode_in = 2'b11;
      repeat (30) @(negedge clk);
      done_m = 1'b0;
      check("run_start_once", start_cnt - sbase, 1);
      check("run_done_clr", done_out, done_m);
      core_halt_in = 1'b1;
      @(negedge clk);
      check("run_halt_done", done_out, 1);
      mode_in = 2'b00;
      repeat (6) @(negedge clk);
      core_halt_in = 1'b0;
      check("run_exit_done", done_out, 0);
      check("run_exit_start", start_cnt - sbase, 1);
      do_frame(2'b10, 4'($urandom_range(0, 14)), 8'($urandom_range(0, 255)));

      // Reset mid-frame.
      base = wr_q.size();
      send_bits(2'b10, 4'd5, 8'hC3, 0, 9);
      @(negedge clk);
      rst     = 1'b1;
      sclk_in = 1'b0;
      mode_in = 2'b00;
      repeat (2) @(negedge clk);
      check_outputs_zero("midrst");
      rst = 1'b0;
      err_m  = 1'b0;
      done_m = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_write", wr_q.size() - base, 0);
      do_frame(2'b01, 4'd15, 8'hFF);
      check("midrst_done", done_out, 1);
      check("midrst_err", frame_err, err_m);

      // Load mode requested while running.
      mode_in = 2'b11;
      repeat (6) @(negedge clk);
      core_halt_in = 1'b1;
      repeat (3) @(negedge clk);
      check("run2_done", done_out, 1);
      mode_in = 2'b01;
      repeat (6) @(negedge clk);
      err_m = 1'b1;
      check("run2_err", frame_err, err_m);
      check("run2_done_clr", done_out, 0);
      mode_in      = 2'b00;
      core_halt_in = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_loader.md
Name: spi_loader

Overview:
- Serial receiver that sits directly downstream of the FPGA demo SPI driver, inside the tiny processor top.
- Deserialises 12-bit frames from sclk_in/mosi_in. Each frame carries a 4-bit address and an 8-bit byte.
- Writes each byte into the instruction memory or the data memory (register file), selected by mode_in.
- Starts the core in run mode and reports load completion or core halt back on done_out.

Parameters:
- ADDR_W, 4, memory address width; frame address field width.
- DATA_W, 8, memory word width; frame data field width.
- Derived localparam FRAME_BITS = ADDR_W + DATA_W = 12.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high, on clock clk.
- sclk_in  in  1  serial clock from driver; mosi changes on falling edge, sampled on rising edge.
- mosi_in  in  1  serial data, LSB first: addr[0..ADDR_W-1], then data[0..DATA_W-1].
- mode_in  in  2  00 idle/gap, 01 imem load, 10 dmem load, 11 run.
- imem_we  out  1  one-cycle imem write strobe.
- imem_addr  out  ADDR_W  imem write address.
- imem_wdata  out  DATA_W  imem write data.
- dmem_we  out  1  one-cycle dmem write strobe.
- dmem_addr  out  ADDR_W  dmem write address.
- dmem_wdata  out  DATA_W  dmem write data.
- core_start  out  1  one-cycle pulse releasing the core.
- core_halt_in  in  1  core has finished execution (level).
- done_out  out  1  to driver done_in: load of top address complete, or core halted in run mode.
- frame_err  out  1  sticky, set on an aborted frame.

Behaviour:
- Reset values:
  - All outputs 0; addr/wdata outputs 0.
  - FSM in IDLE; bit counter 0; shift register 0; sclk_q 0.
- Rising-edge detect: rise = sclk_in & ~sclk_q, where sclk_q is registered every clk.
- FSM states: IDLE, RX, WR, RUN.
- IDLE:
  - mode_in in {01,10} and rise: shift the bit in, cnt <= 1, latch frame mode to fmode, go to RX.
  - mode_in == 11: pulse core_start, clear done_out, go to RUN.
- RX:
  - On each rise: shift right, mosi_in enters the MSB, cnt++.
  - When cnt reaches FRAME_BITS, go to WR on the next clk; no further rise is needed.
  - mode_in != fmode while cnt < FRAME_BITS (including 00): abort, set frame_err, cnt <= 0, go to IDLE. No write occurs.
  - Gaps of mode 00 are legal only between frames.
- WR (exactly 1 cycle):
  - Assert imem_we if fmode == 01, dmem_we if fmode == 10.
  - addr = sr[ADDR_W-1:0], wdata = sr[FRAME_BITS-1:ADDR_W].
  - If addr is all ones, set done_out; otherwise clear it.
  - Go to IDLE.
  - Write latency: one clk after the clk in which cnt reaches FRAME_BITS.
- done_out in load modes:
  - Level signal; holds through mode 00 gaps.
  - Cleared at the first sampled bit of a new frame whose mode differs from the mode that set it.
- RUN:
  - done_out <= core_halt_in, registered.
  - mode_in == 00: clear done_out, go to IDLE.
  - Mode 01/10 while in RUN: also go to IDLE, set frame_err, clear done_out.
- core_start: a single pulse per entry into RUN. Mode held at 11 for many cycles does not re-pulse.
- Writes to the same address overwrite the previous value. No write-mask tracking.
- rst mid-frame: partial frame discarded, no write strobe, frame_err cleared.
- frame_err is cleared only by rst.

Optional Feature:
- Macro: SPI_LOADER_SYNC_EN.
- Defined:
  - sclk_in, mosi_in and mode_in each pass through a 2-flop synchroniser (reset 0) before edge detect.
  - All input-related timing shifts by +2 clk.
  - Requires clk ≥ 4× the sclk frequency.
- Undefined: inputs used directly; driver and loader share clk.

Test Plan:
- imem frame: mode 01, serial bits 1,1,0,0, 1,0,1,0,0,1,0,1 (addr 3, data 0xA5) -> one imem_we pulse with imem_addr=3, imem_wdata=0xA5; dmem_we stays 0; done_out=0.
- Full dmem load: 16 frames of mode 10, addr 0..15, data = 0x10+addr, with 00 gaps -> 16 dmem_we pulses with matching values; done_out rises after addr 15 and holds through a following mode 00.
- Abort: mode 01, 6 bits sent, mode drops to 00 -> no imem_we; frame_err=1. Next complete frame (addr 0, 0x3C) writes correctly.
- Run: mode 11 after load -> exactly one core_start pulse and done_out=0. core_halt_in=1 -> done_out=1 one clk later. Mode 00 -> done_out=0, FSM back in IDLE.
- Reset mid-frame: rst asserted after 9 bits -> no write, all outputs 0. Next frame addr 15, 0xFF -> write and done_out=1.
- With SPI_LOADER_SYNC_EN and sclk at clk/4: frame addr 7, data 0x81 -> correct write, latency +2 clk versus the unsynchronised build.
